// File: rtl/speed_effect_ctrl.sv
// Effect sequencer for the player velocity path: pickup/level events -> boost/curse flags, energy, speed_limit.
// Optional stacking of repeated power-ups in BOOST is enabled by defining EFFECT_STACK_EN.
module speed_effect_ctrl #(
  parameter int TICK_DIV    = 100_000,
  parameter int BOOST_MS    = 5000,
  parameter int CURSE_MS    = 3000,
  parameter int COOLDOWN_MS = 1000,
  parameter int BASE_SPEED  = 2_777_776,
  parameter int SPEED_STEP  = 100_000,
  parameter int MIN_SPEED   = 1_666_666,
  parameter int ENERGY_MAX  = 1000
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        en,
  input  logic        moving,
  input  logic        power_up_pick,
  input  logic        curse_pick,
  input  logic        level_up,
  output logic        power_up_active,
  output logic        curse_active,
  output logic [10:0] energy,
  output logic [31:0] speed_limit,
  output logic [15:0] time_left,
  output logic        pick_denied
);

  typedef enum logic [1:0] {ST_NORMAL, ST_BOOST, ST_CURSE, ST_COOLDOWN} state_t;

  localparam int              PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0]     T_BOOST  = 16'(BOOST_MS);
  localparam logic [15:0]     T_CURSE  = 16'(CURSE_MS);
  localparam logic [15:0]     T_COOL   = 16'(COOLDOWN_MS);
  localparam logic [10:0]     E_MAX    = 11'(ENERGY_MAX);
  localparam logic [31:0]     SPD_BASE = 32'(BASE_SPEED);
  localparam logic [31:0]     SPD_STEP = 32'(SPEED_STEP);
  localparam logic [31:0]     SPD_MIN  = 32'(MIN_SPEED);
  localparam logic [32:0]     SPD_CLAMP_AT = {1'b0, SPD_MIN} + {1'b0, SPD_STEP};

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   time_left_q, time_left_d;
  logic [10:0]   energy_q, energy_d;
  logic [31:0]   speed_limit_q, speed_limit_d;
  logic          pick_denied_q, pick_denied_d;
  logic          tick;
  logic [15:0]   tl_dec;
  logic [15:0]   boost_reload;
  logic [10:0]   drain;

  assign tick   = en && (presc_q == PRE_LAST);
  assign tl_dec = (tick && time_left_q != 16'd0) ? time_left_q - 16'd1 : time_left_q;
  assign drain  = (state_q == ST_BOOST) ? 11'd2 : 11'd1;

`ifdef EFFECT_STACK_EN
  localparam logic [16:0] T_STACK_CAP = 17'(2 * BOOST_MS);
  logic [16:0] stack_sum;
  assign stack_sum    = {1'b0, time_left_q} + {1'b0, T_BOOST};
  assign boost_reload = (stack_sum > T_STACK_CAP) ? T_STACK_CAP[15:0] : stack_sum[15:0];
`else
  assign boost_reload = T_BOOST;
`endif

  always_comb begin
    presc_d = presc_q;
    if (en) presc_d = tick ? '0 : presc_q + 1'b1;

    energy_d = energy_q;
    if (tick) begin
      if (moving) energy_d = (energy_q > drain) ? energy_q - drain : 11'd0;
      else        energy_d = (energy_q >= E_MAX) ? E_MAX : energy_q + 11'd1;
    end

    // Compare before subtracting so the limit never wraps below the floor.
    speed_limit_d = speed_limit_q;
    if (level_up) begin
      if ({1'b0, speed_limit_q} < SPD_CLAMP_AT) speed_limit_d = SPD_MIN;
      else                                      speed_limit_d = speed_limit_q - SPD_STEP;
    end
  end

  // Pickups take priority over timer expiry; loads override the tick decrement.
  always_comb begin
    state_d       = state_q;
    time_left_d   = tl_dec;
    pick_denied_d = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        time_left_d = '0;
        if (power_up_pick) begin
          state_d       = ST_BOOST;
          time_left_d   = T_BOOST;
          pick_denied_d = curse_pick;
        end else if (curse_pick) begin
          state_d     = ST_CURSE;
          time_left_d = T_CURSE;
        end
      end
      ST_BOOST: begin
        pick_denied_d = curse_pick;
        if (power_up_pick) begin
          time_left_d = boost_reload;
        end else if (time_left_q == 16'd0) begin
          state_d     = ST_COOLDOWN;
          time_left_d = T_COOL;
        end
      end
      ST_CURSE: begin
        if (power_up_pick) begin
          state_d     = ST_BOOST;
          time_left_d = T_BOOST;
        end else if (curse_pick) begin
          time_left_d = T_CURSE;
        end else if (time_left_q == 16'd0) begin
          state_d     = ST_NORMAL;
          time_left_d = '0;
        end
      end
      ST_COOLDOWN: begin
        pick_denied_d = power_up_pick;
        if (curse_pick) begin
          state_d     = ST_CURSE;
          time_left_d = T_CURSE;
        end else if (time_left_q == 16'd0) begin
          state_d     = ST_NORMAL;
          time_left_d = '0;
        end
      end
      default: begin
        state_d     = ST_NORMAL;
        time_left_d = '0;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q       <= ST_NORMAL;
      presc_q       <= '0;
      time_left_q   <= '0;
      energy_q      <= E_MAX;
      speed_limit_q <= SPD_BASE;
      pick_denied_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      time_left_q   <= time_left_d;
      energy_q      <= energy_d;
      speed_limit_q <= speed_limit_d;
      pick_denied_q <= pick_denied_d;
    end
  end

  assign power_up_active = (state_q == ST_BOOST);
  assign curse_active    = (state_q == ST_CURSE);
  assign energy          = energy_q;
  assign speed_limit     = speed_limit_q;
  assign time_left       = time_left_q;
  assign pick_denied     = pick_denied_q;

endmodule

// File: tb/tb_speed_effect_ctrl.sv
// Bench for speed_effect_ctrl: directed stimulus, per-cycle reference model, literal spot checks.
module tb_speed_effect_ctrl;

  localparam int TD    = 10;
  localparam int BMS   = 5;
  localparam int CMS   = 3;
  localparam int COMS  = 2;
  localparam longint BASE = 2_777_776;
  localparam longint STEP = 100_000;
  localparam longint MINS = 1_666_666;
  localparam int EMAX  = 1000;

  localparam int M_NORMAL = 0, M_BOOST = 1, M_CURSE = 2, M_COOL = 3;

  logic        sysclk = 1'b0;
  logic        reset = 1'b1, en = 1'b0, moving = 1'b0;
  logic        power_up_pick = 1'b0, curse_pick = 1'b0, level_up = 1'b0;
  logic        power_up_active, curse_active, pick_denied;
  logic [10:0] energy;
  logic [31:0] speed_limit;
  logic [15:0] time_left;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 0;

  speed_effect_ctrl #(
    .TICK_DIV(TD), .BOOST_MS(BMS), .CURSE_MS(CMS), .COOLDOWN_MS(COMS)
  ) dut (
    .sysclk(sysclk), .reset(reset), .en(en), .moving(moving),
    .power_up_pick(power_up_pick), .curse_pick(curse_pick), .level_up(level_up),
    .power_up_active(power_up_active), .curse_active(curse_active),
    .energy(energy), .speed_limit(speed_limit), .time_left(time_left),
    .pick_denied(pick_denied)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: millisecond counter, effect state and resources tracked as plain integers.
  int     m_state, m_tl, m_energy, m_pre;
  longint m_speed;
  bit     m_den, m_tick;

  always @(posedge sysclk) begin
    if (reset) begin
      m_state = M_NORMAL; m_tl = 0; m_energy = EMAX; m_speed = BASE; m_den = 0; m_pre = 0;
    end else begin
      m_tick = en && (m_pre == TD - 1);
      if (en) m_pre = (m_pre + 1) % TD;
      if (m_tick) begin
        if (moving) m_energy = m_energy - ((m_state == M_BOOST) ? 2 : 1);
        else        m_energy = m_energy + 1;
        if (m_energy < 0)    m_energy = 0;
        if (m_energy > EMAX) m_energy = EMAX;
      end
      if (level_up) m_speed = (m_speed - STEP < MINS) ? MINS : m_speed - STEP;
      m_den = 0;
      if (m_state == M_NORMAL) begin
        if (power_up_pick) begin m_state = M_BOOST; m_tl = BMS; m_den = curse_pick; end
        else if (curse_pick) begin m_state = M_CURSE; m_tl = CMS; end
      end else if (m_state == M_BOOST) begin
        m_den = curse_pick;
`ifdef EFFECT_STACK_EN
        if (power_up_pick) m_tl = (m_tl + BMS > 2 * BMS) ? 2 * BMS : m_tl + BMS;
`else
        if (power_up_pick) m_tl = BMS;
`endif
        else if (m_tl == 0) begin m_state = M_COOL; m_tl = COMS; end
        else if (m_tick) m_tl--;
      end else if (m_state == M_CURSE) begin
        if (power_up_pick) begin m_state = M_BOOST; m_tl = BMS; end
        else if (curse_pick) m_tl = CMS;
        else if (m_tl == 0) m_state = M_NORMAL;
        else if (m_tick) m_tl--;
      end else begin
        m_den = power_up_pick;
        if (curse_pick) begin m_state = M_CURSE; m_tl = CMS; end
        else if (m_tl == 0) m_state = M_NORMAL;
        else if (m_tick) m_tl--;
      end
    end
  end

  always @(negedge sysclk) begin
    if (chk_on) begin
      chk("cmp_power_up_active", power_up_active, m_state == M_BOOST);
      chk("cmp_curse_active", curse_active, m_state == M_CURSE);
      chk("cmp_energy", energy, m_energy);
      chk("cmp_speed_limit", speed_limit, m_speed);
      chk("cmp_time_left", time_left, m_tl);
      chk("cmp_pick_denied", pick_denied, m_den);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic pulse(input bit pu, input bit cu, input bit lu);
    power_up_pick = pu; curse_pick = cu; level_up = lu;
    step(1);
    power_up_pick = 0; curse_pick = 0; level_up = 0;
  endtask

  initial begin
    int     cnt;
    longint exp_spd;

    @(posedge sysclk); #1;
    chk_on = 1;
    step(2);
    reset = 0; en = 1;

    // Idle after reset
    step(100);
    chk("rst_energy", energy, 1000);
    chk("rst_speed", speed_limit, 2_777_776);
    chk("rst_pu_active", power_up_active, 0);
    chk("rst_curse_active", curse_active, 0);
    chk("rst_time_left", time_left, 0);

    // Boost, expiry, cooldown denial
    pulse(1, 0, 0);
    chk("boost_active", power_up_active, 1);
    chk("boost_tl", time_left, 5);
    cnt = 0;
    while (power_up_active && cnt < 100) begin step(1); cnt++; end
    chk("boost_expired", power_up_active, 0);
    chk("cool_tl", time_left, 2);
    pulse(1, 0, 0);
    chk("cool_denied", pick_denied, 1);
    chk("cool_no_boost", power_up_active, 0);
    step(1);
    chk("cool_denied_clr", pick_denied, 0);
    step(40);
    chk("normal_tl", time_left, 0);

    // Curse cured by power-up
    pulse(0, 1, 0);
    chk("curse_active", curse_active, 1);
    chk("curse_tl", time_left, 3);
    step(14);
    pulse(1, 0, 0);
    chk("cure_curse_off", curse_active, 0);
    chk("cure_boost_on", power_up_active, 1);
    step(120);

    // Simultaneous pickups
    pulse(1, 1, 0);
    chk("both_boost", power_up_active, 1);
    chk("both_no_curse", curse_active, 0);
    chk("both_denied", pick_denied, 1);
    step(1);
    chk("both_denied_clr", pick_denied, 0);
    step(100);

    // Energy drain to zero in BOOST, then recharge
    moving = 1;
    cnt = 0;
    while (energy != 3 && cnt < 11000) begin step(1); cnt++; end
    chk("e_reach3", energy, 3);
    pulse(1, 0, 0);
    step(9);
    chk("e_boost_1", energy, 1);
    step(10);
    chk("e_boost_0", energy, 0);
    step(10);
    chk("e_hold_0", energy, 0);
    moving = 0;
    step(10);
    chk("e_charge_1", energy, 1);
    step(10);
    chk("e_charge_2", energy, 2);
    step(100);

    // Level stepping with clamp, en toggled to show independence
    exp_spd = 2_777_776;
    for (int i = 1; i <= 12; i++) begin
      en = i[0];
      pulse(0, 0, 1);
      exp_spd = (i == 12) ? 64'd1_666_666 : 64'd2_777_776 - 64'd100_000 * i;
      chk("level_speed", speed_limit, exp_spd);
      step(1);
    end
    chk("level_first_seen", 2_777_776 - 100_000, 2_677_776 + 0 * speed_limit);
    chk("level_floor", speed_limit, 1_666_666);

    // Pause freezes the curse timer
    en = 0;
    pulse(0, 1, 0);
    step(50);
    chk("pause_curse", curse_active, 1);
    chk("pause_tl", time_left, 3);
    en = 1;
    step(60);
    chk("resume_curse_done", curse_active, 0);
    chk("resume_tl", time_left, 0);

    // Reset during an effect
    pulse(1, 0, 0);
    reset = 1;
    step(1);
    chk("mrst_pu_active", power_up_active, 0);
    chk("mrst_tl", time_left, 0);
    chk("mrst_speed", speed_limit, 2_777_776);
    chk("mrst_energy", energy, 1000);
    reset = 0;
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
